switch_input_debouncer: RTL

//  Input-side counterpart of the seven-segment Digit driver: conditions raw switch/key pins
//  (SWI, PI4 headers) before they reach SoC GPIO.
//  Per channel:
//  - synchronizes the pin;
//  - rejects bounce and glitches shorter than DEB_CYCLES;
//  - publishes a clean level;
//  - latches sticky rise/fall events that firmware clears (write-1-to-clear).

---
 rtl/switch_input_debouncer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/switch_input_debouncer.sv
// Per-channel switch conditioner: 2-flop synchronizer, counting debouncer, sticky W1C rise/fall events.
// Define SWDEB_IRQ_EN to build the registered, maskable interrupt summary; otherwise irq is tied to 0.
module switch_input_debouncer #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             RST,
  input  logic [WIDTH-1:0] pin_in,
  input  logic [WIDTH-1:0] evt_clr,
  input  logic [WIDTH-1:0] irq_mask,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_evt,
  output logic [WIDTH-1:0] fall_evt,
  output logic             irq
);

  localparam int CNT_W = (DEB_CYCLES < 1) ? 1 : $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {ST_STABLE, ST_PENDING} deb_state_t;

  logic [WIDTH-1:0] s1_q, s2_q;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= pin_in;
      s2_q <= s1_q;
    end
  end

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             set_rise, set_fall;

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      level_d  = level_q;
      set_rise = 1'b0;
      set_fall = 1'b0;
      case (state_q)
        ST_STABLE: begin
          cnt_d = '0;
          if (s2_q[gi] != level_q) begin
            if (DEB_CYCLES == 1) begin
              level_d  = s2_q[gi];
              set_rise = s2_q[gi];
              set_fall = ~s2_q[gi];
            end else begin
              cnt_d   = CNT_ONE;
              state_d = ST_PENDING;
            end
          end
        end
        ST_PENDING: begin
          if (s2_q[gi] == level_q) begin
            cnt_d   = '0;
            state_d = ST_STABLE;
          end else if (cnt_q == CNT_LAST) begin
            level_d  = s2_q[gi];
            cnt_d    = '0;
            state_d  = ST_STABLE;
            set_rise = s2_q[gi];
            set_fall = ~s2_q[gi];
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_STABLE;
        end
      endcase
      // A set in the same cycle as a clear wins so no event is ever lost.
      rise_d = (rise_q & ~evt_clr[gi]) | set_rise;
      fall_d = (fall_q & ~evt_clr[gi]) | set_fall;
    end

    always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
        state_q <= ST_STABLE;
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign level_out[gi] = level_q;
    assign rise_evt[gi]  = rise_q;
    assign fall_evt[gi]  = fall_q;
  end

`ifdef SWDEB_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = |((rise_evt | fall_evt) & ~irq_mask);
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  logic unused_irq_mask;
  assign unused_irq_mask = ^irq_mask;
  assign irq = 1'b0;
`endif

endmodule
